// File: rtl/issue_pair_queue.sv
// Front-end instruction buffer that issues the oldest instruction alone,
// or the oldest two together when they form a legal INT/FP pair.
module issue_pair_queue #(
    parameter int depth_p          = 4,
    parameter int payload_width_p  = 32,
    parameter int reg_addr_width_p = 5,
    parameter int ctr_width_p      = 32
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [1:0]                       enq_v_i,
    output logic                             enq_ready_o,
    input  logic [1:0][payload_width_p-1:0]  enq_payload_i,
    input  logic [1:0][reg_addr_width_p-1:0] enq_rd_i,
    input  logic [1:0][reg_addr_width_p-1:0] enq_rs1_i,
    input  logic [1:0][reg_addr_width_p-1:0] enq_rs2_i,
    input  logic [1:0]                       enq_write_rd_i,
    input  logic [1:0]                       enq_read_rs1_i,
    input  logic [1:0]                       enq_read_rs2_i,
    input  logic [1:0]                       enq_is_fp_i,
    input  logic [1:0]                       enq_is_special_i,
    input  logic                             dual_en_i,
    input  logic                             flush_i,
    output logic [1:0]                       issue_v_o,
    output logic [1:0][payload_width_p-1:0]  issue_payload_o,
    input  logic                             issue_ready_i,
    output logic [ctr_width_p-1:0]           dual_cnt_o
);

    localparam int ptr_w = $clog2(depth_p);
    localparam int cnt_w = $clog2(depth_p + 1);

    typedef logic [ptr_w-1:0]       ptr_t;
    typedef logic [cnt_w-1:0]       cnt_t;
    typedef logic [ctr_width_p-1:0] ctr_t;

    typedef struct packed {
        logic [payload_width_p-1:0]  payload;
        logic [reg_addr_width_p-1:0] rd;
        logic [reg_addr_width_p-1:0] rs1;
        logic [reg_addr_width_p-1:0] rs2;
        logic                        write_rd;
        logic                        read_rs1;
        logic                        read_rs2;
        logic                        is_fp;
        logic                        is_special;
    } entry_t;

    localparam cnt_t enq_lvl = cnt_t'(depth_p - 2);

    entry_t mem [depth_p];
    ptr_t   head_r;
    ptr_t   tail_r;
    cnt_t   count_r;
    ctr_t   dual_r;

    entry_t in_e [2];
    entry_t h0;
    entry_t h1;
    logic   raw;
    logic   waw;
    logic   pair_ok;
    logic   enq_fire;
    cnt_t   enq_n;
    cnt_t   deq_n;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            in_e[i] = '{
                payload:    enq_payload_i[i],
                rd:         enq_rd_i[i],
                rs1:        enq_rs1_i[i],
                rs2:        enq_rs2_i[i],
                write_rd:   enq_write_rd_i[i],
                read_rs1:   enq_read_rs1_i[i],
                read_rs2:   enq_read_rs2_i[i],
                is_fp:      enq_is_fp_i[i],
                is_special: enq_is_special_i[i]
            };
        end
    end

    assign h0 = mem[head_r];
    assign h1 = mem[head_r + ptr_t'(1)];

    // Register matches are deliberately conservative: x0 and file are ignored.
    assign raw = h0.write_rd
               & ((h1.read_rs1 & (h0.rd == h1.rs1))
               |  (h1.read_rs2 & (h0.rd == h1.rs2)));
    assign waw = h0.write_rd & h1.write_rd & (h0.rd == h1.rd);

    assign pair_ok = (count_r >= cnt_t'(2))
                   & dual_en_i
                   & ~h0.is_special
                   & ~h1.is_special
                   & (h0.is_fp ^ h1.is_fp)
                   & ~raw
                   & ~waw;

    always_comb begin
        issue_v_o = 2'b00;
        priority case (1'b1)
            (flush_i || count_r == '0): issue_v_o = 2'b00;
            pair_ok:                    issue_v_o = 2'b11;
            default:                    issue_v_o = 2'b01;
        endcase
    end

    assign issue_payload_o[0] = h0.payload;
    assign issue_payload_o[1] = h1.payload;

    assign enq_ready_o = (count_r <= enq_lvl);
    assign enq_fire    = enq_v_i[0] & enq_ready_o & ~flush_i;
    assign enq_n       = enq_fire
                       ? (enq_v_i[1] ? cnt_t'(2) : cnt_t'(1))
                       : '0;
    assign deq_n       = issue_ready_i
                       ? cnt_t'(issue_v_o[0]) + cnt_t'(issue_v_o[1])
                       : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem     <= '{default: '0};
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (flush_i) begin
            head_r  <= tail_r;
            count_r <= '0;
        end else begin
            head_r  <= head_r + ptr_t'(deq_n);
            tail_r  <= tail_r + ptr_t'(enq_n);
            count_r <= count_r + enq_n - deq_n;
            if (enq_fire)
                mem[tail_r] <= in_e[0];
            if (enq_fire && enq_v_i[1])
                mem[tail_r + ptr_t'(1)] <= in_e[1];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            dual_r <= '0;
        else if (issue_v_o == 2'b11 && issue_ready_i && dual_r != '1)
            dual_r <= dual_r + ctr_t'(1);
    end

    assign dual_cnt_o = dual_r;

    a_enq_lanes: assert property (
        @(posedge clk_i) disable iff (reset_i) enq_v_i != 2'b10
    );

endmodule

// File: tb/tb_issue_pair_queue.sv
// Scoreboard bench for issue_pair_queue: directed pairing, full,
// stall, wrap, flush, counter saturation and async reset cases.
module tb_issue_pair_queue;

    logic             clk_i;
    logic             reset_i;
    logic [1:0]       enq_v;
    logic             enq_ready;
    logic [1:0][31:0] enq_payload;
    logic [1:0][4:0]  enq_rd;
    logic [1:0][4:0]  enq_rs1;
    logic [1:0][4:0]  enq_rs2;
    logic [1:0]       enq_wr;
    logic [1:0]       enq_r1;
    logic [1:0]       enq_r2;
    logic [1:0]       enq_fp;
    logic [1:0]       enq_sp;
    logic             dual_en;
    logic             flush;
    logic [1:0]       issue_v;
    logic [1:0][31:0] issue_payload;
    logic             issue_ready;
    logic [3:0]       dual_cnt;

    issue_pair_queue #(
        .depth_p(4),
        .payload_width_p(32),
        .reg_addr_width_p(5),
        .ctr_width_p(4)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .enq_v_i(enq_v),
        .enq_ready_o(enq_ready),
        .enq_payload_i(enq_payload),
        .enq_rd_i(enq_rd),
        .enq_rs1_i(enq_rs1),
        .enq_rs2_i(enq_rs2),
        .enq_write_rd_i(enq_wr),
        .enq_read_rs1_i(enq_r1),
        .enq_read_rs2_i(enq_r2),
        .enq_is_fp_i(enq_fp),
        .enq_is_special_i(enq_sp),
        .dual_en_i(dual_en),
        .flush_i(flush),
        .issue_v_o(issue_v),
        .issue_payload_o(issue_payload),
        .issue_ready_i(issue_ready),
        .dual_cnt_o(dual_cnt)
    );

    typedef struct packed {
        logic [31:0] p;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        wr;
        logic        r1;
        logic        r2;
        logic        fp;
        logic        sp;
    } ins_t;

    typedef struct packed {
        logic [1:0]  v;
        logic [31:0] p0;
        logic [31:0] p1;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   exp_dual = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", n, act, exp);
        end
    endtask

    function automatic ins_t mk(input logic [31:0] p, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic wr, input logic r1, input logic r2,
                                input logic fp, input logic sp);
        return '{p: p, rd: rd, rs1: rs1, rs2: rs2,
                 wr: wr, r1: r1, r2: r2, fp: fp, sp: sp};
    endfunction

    function automatic ins_t i_int(input logic [31:0] p);
        return mk(p, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic ins_t i_fp(input logic [31:0] p);
        return mk(p, 5'd20, 5'd21, 5'd22, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_lane(input int l, input ins_t x);
        enq_payload[l] = x.p;
        enq_rd[l]      = x.rd;
        enq_rs1[l]     = x.rs1;
        enq_rs2[l]     = x.rs2;
        enq_wr[l]      = x.wr;
        enq_r1[l]      = x.r1;
        enq_r2[l]      = x.r2;
        enq_fp[l]      = x.fp;
        enq_sp[l]      = x.sp;
    endtask

    task automatic enq(input logic [1:0] v, input ins_t a, input ins_t b);
        set_lane(0, a);
        set_lane(1, b);
        enq_v = v;
        cyc();
        enq_v = 2'b00;
    endtask

    task automatic push(input logic [1:0] v, input logic [31:0] p0,
                        input logic [31:0] p1);
        sb.push_back('{v: v, p0: p0, p1: p1});
        if (v == 2'b11 && exp_dual != 15)
            exp_dual++;
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 40 && sb.size() != 0; i++)
            cyc();
        chk("drain_left", sb.size(), 0);
    endtask

    always @(negedge clk_i) begin
        if (!reset_i && issue_v != 2'b00 && issue_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue got=%b want=none", issue_v);
            end else begin
                mon_e = sb.pop_front();
                chk("issue_v", 32'(issue_v), 32'(mon_e.v));
                chk("issue_p0", issue_payload[0], mon_e.p0);
                if (mon_e.v == 2'b11)
                    chk("issue_p1", issue_payload[1], mon_e.p1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        reset_i     = 1'b1;
        enq_v       = 2'b00;
        dual_en     = 1'b1;
        flush       = 1'b0;
        issue_ready = 1'b0;
        set_lane(0, i_int(0));
        set_lane(1, i_int(0));
        cyc();
        chk("rst_issue_v", 32'(issue_v), 0);
        chk("rst_enq_ready", 32'(enq_ready), 1);
        chk("rst_dual", 32'(dual_cnt), 0);
        chk("rst_payload0", issue_payload[0], 0);
        cyc();
        reset_i = 1'b0;
        issue_ready = 1'b1;

        // INT add x1 + FP fadd f2: dual issue
        push(2'b11, 32'h101, 32'h102);
        enq(2'b11, mk(32'h101, 5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0),
                   mk(32'h102, 5'd2, 5'd3, 5'd4, 1, 1, 1, 1, 0));
        wait_empty();
        chk("t1_dual", 32'(dual_cnt), 32'(exp_dual));
        chk("t1_empty_v", 32'(issue_v), 0);

        // addi x5 ; add x6,x5,x7 : both INT
        push(2'b01, 32'h201, 0);
        push(2'b01, 32'h202, 0);
        enq(2'b11, mk(32'h201, 5'd5, 5'd0, 5'd0, 1, 1, 0, 0, 0),
                   mk(32'h202, 5'd6, 5'd5, 5'd7, 1, 1, 1, 0, 0));
        wait_empty();

        // lw x5 ; fadd f1,f5,f6 : conservative RAW across files
        push(2'b01, 32'h301, 0);
        push(2'b01, 32'h302, 0);
        enq(2'b11, mk(32'h301, 5'd5, 5'd1, 5'd0, 1, 1, 0, 0, 0),
                   mk(32'h302, 5'd1, 5'd5, 5'd6, 1, 1, 1, 1, 0));
        wait_empty();
        chk("t2_dual", 32'(dual_cnt), 32'(exp_dual));

        // branch + FP op
        push(2'b01, 32'h401, 0);
        push(2'b01, 32'h402, 0);
        enq(2'b11, mk(32'h401, 5'd0, 5'd1, 5'd2, 0, 1, 1, 0, 1),
                   i_fp(32'h402));
        wait_empty();

        // legal pair with dual issue disabled
        dual_en = 1'b0;
        push(2'b01, 32'h501, 0);
        push(2'b01, 32'h502, 0);
        enq(2'b11, i_int(32'h501), i_fp(32'h502));
        wait_empty();
        dual_en = 1'b1;

        // WAW on rd 7
        push(2'b01, 32'h601, 0);
        push(2'b01, 32'h602, 0);
        enq(2'b11, mk(32'h601, 5'd7, 5'd1, 5'd2, 1, 1, 1, 0, 0),
                   mk(32'h602, 5'd7, 5'd3, 5'd4, 1, 1, 1, 1, 0));
        wait_empty();
        chk("t3_dual", 32'(dual_cnt), 32'(exp_dual));

        // single entry shifts pointers so the later pair straddles 3/0
        push(2'b01, 32'h701, 0);
        enq(2'b01, i_int(32'h701), i_int(0));
        wait_empty();

        // fill to 3 while stalled
        issue_ready = 1'b0;
        enq(2'b11, i_int(32'h810), i_fp(32'h811));
        enq(2'b01, i_int(32'h812), i_int(0));
        chk("full_ready", 32'(enq_ready), 0);
        set_lane(0, i_int(32'hdead));
        set_lane(1, i_fp(32'hbeef));
        enq_v = 2'b11;
        for (int i = 0; i < 5; i++) begin
            chk("stall_v", 32'(issue_v), 3);
            chk("stall_p0", issue_payload[0], 32'h810);
            chk("stall_p1", issue_payload[1], 32'h811);
            cyc();
        end
        enq_v = 2'b00;
        push(2'b11, 32'h810, 32'h811);
        issue_ready = 1'b1;
        cyc();
        issue_ready = 1'b0;
        chk("after_pop_v", 32'(issue_v), 1);
        push(2'b11, 32'h812, 32'h813);
        enq(2'b01, i_fp(32'h813), i_int(0));
        issue_ready = 1'b1;
        wait_empty();
        chk("wrap_dual", 32'(dual_cnt), 32'(exp_dual));

        // flush with count 3, enqueue and ready all asserted
        issue_ready = 1'b0;
        enq(2'b11, i_int(32'h901), i_fp(32'h902));
        enq(2'b01, i_int(32'h903), i_int(0));
        set_lane(0, i_int(32'h9f0));
        set_lane(1, i_fp(32'h9f1));
        enq_v = 2'b11;
        flush = 1'b1;
        issue_ready = 1'b1;
        #1;
        chk("flush_v", 32'(issue_v), 0);
        cyc();
        flush = 1'b0;
        enq_v = 2'b00;
        chk("post_flush_v", 32'(issue_v), 0);
        chk("post_flush_ready", 32'(enq_ready), 1);
        chk("post_flush_dual", 32'(dual_cnt), 32'(exp_dual));
        for (int i = 0; i < 3; i++)
            cyc();
        push(2'b11, 32'ha01, 32'ha02);
        enq(2'b11, i_int(32'ha01), i_fp(32'ha02));
        wait_empty();

        // 17 back-to-back dual issues saturate the 4-bit counter
        for (int i = 0; i < 17; i++) begin
            push(2'b11, 32'hb00 + 32'(2 * i), 32'hb01 + 32'(2 * i));
            enq(2'b11, i_int(32'hb00 + 32'(2 * i)),
                       i_fp(32'hb01 + 32'(2 * i)));
        end
        wait_empty();
        chk("sat_dual", 32'(dual_cnt), 32'(exp_dual));
        chk("sat_is_15", 32'(dual_cnt), 15);

        // asynchronous reset mid-cycle with entries queued
        issue_ready = 1'b0;
        enq(2'b11, i_int(32'hc01), i_fp(32'hc02));
        #2;
        reset_i = 1'b1;
        #1;
        chk("arst_v", 32'(issue_v), 0);
        chk("arst_ready", 32'(enq_ready), 1);
        chk("arst_dual", 32'(dual_cnt), 0);
        chk("arst_p0", issue_payload[0], 0);
        chk("arst_p1", issue_payload[1], 0);
        exp_dual = 0;
        cyc();
        reset_i = 1'b0;
        issue_ready = 1'b1;
        push(2'b11, 32'hd01, 32'hd02);
        enq(2'b11, i_int(32'hd01), i_fp(32'hd02));
        wait_empty();
        chk("final_dual", 32'(dual_cnt), 32'(exp_dual));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
